keycode_frame_input: RTL and testbench

Input-conditioning stage between the MicroBlaze USB keycode GPIO words and the game logic (player, FSM). Scans both 32-bit keycode words for configured HID usage codes and debounces each action. Latches held levels and sticky press events once per video frame on the vsync rising edge, so the player modules see one coherent input snapshot per `frame_clk` period. Also emits one-cycle menu key events for the FSM.

---
 rtl/keycode_frame_input.sv | 188 ++++++++++++++++++
 tb/tb_keycode_frame_input.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keycode_frame_input.sv
// keycode_frame_input: scans the two USB keycode GPIO words for the configured
// HID usage codes, debounces each action, and latches one coherent snapshot of
// held levels and sticky press events per video frame (vsync rising edge).
// Menu keys (Enter/Up/Down) produce one-cycle events for the game FSM.
// Optional feature macro: KEYIN_DEBOUNCE_EN (tick divider + per-bit debounce
// counters). Without it the stable vector is the registered raw match vector.
module keycode_frame_input #(
    parameter int         SAMPLE_DIV = 100000,
    parameter int         DEBOUNCE   = 4,
    parameter logic [7:0] KEY_LEFT   = 8'h04,
    parameter logic [7:0] KEY_RIGHT  = 8'h07,
    parameter logic [7:0] KEY_JUMP   = 8'h1A,
    parameter logic [7:0] KEY_KICK   = 8'h2C,
    parameter logic [7:0] KEY_ENTER  = 8'h28,
    parameter logic [7:0] KEY_UP     = 8'h52,
    parameter logic [7:0] KEY_DOWN   = 8'h51
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] keycode0,
    input  logic [31:0] keycode1,
    input  logic        vsync,
    output logic [3:0]  act_held,
    output logic [3:0]  act_press,
    output logic        frame_strobe,
    output logic [7:0]  menu_key,
    output logic        menu_valid
);

    // Action bit order: {down, up, enter, kick, jump, right, left}
    logic [31:0] kc0_q;
    logic [31:0] kc1_q;
    logic [63:0] kc_all;
    logic [7:0]  kc_byte;
    logic [6:0]  match;
    logic [6:0]  raw;
    logic [6:0]  stable;
    logic [6:0]  stable_d;
    logic [6:0]  rise;
    logic [3:0]  pend;
    logic        vs_s1;
    logic        vs_s2;
    logic        vs_s3;
    logic        vs_rise;

    assign kc_all = {kc1_q, kc0_q};

    // Register the GPIO keycode words
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            kc0_q <= '0;
            kc1_q <= '0;
        end else begin
            kc0_q <= keycode0;
            kc1_q <= keycode1;
        end
    end

    // Compare all eight bytes against every configured code; 8'h00 is "no key"
    always_comb begin
        match   = '0;
        kc_byte = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            kc_byte = kc_all[8*i +: 8];
            if (kc_byte != 8'h00) begin
                if (kc_byte == KEY_LEFT)  match[0] = 1'b1;
                if (kc_byte == KEY_RIGHT) match[1] = 1'b1;
                if (kc_byte == KEY_JUMP)  match[2] = 1'b1;
                if (kc_byte == KEY_KICK)  match[3] = 1'b1;
                if (kc_byte == KEY_ENTER) match[4] = 1'b1;
                if (kc_byte == KEY_UP)    match[5] = 1'b1;
                if (kc_byte == KEY_DOWN)  match[6] = 1'b1;
            end
        end
    end

    // Raw match register; an ErrorRollOver report keeps the previous vector
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            raw <= '0;
        end else if (kc0_q[7:0] != 8'h01) begin
            raw <= match;
        end
    end

`ifdef KEYIN_DEBOUNCE_EN
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [6:0][3:0]  cnt;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample divider producing one tick every SAMPLE_DIV cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Per-bit debounce: DEBOUNCE consecutive differing ticks flip the level
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable <= '0;
            cnt    <= '0;
        end else if (tick) begin
            for (int unsigned i = 0; i < 7; i++) begin
                if (raw[i] != stable[i]) begin
                    if (cnt[i] == 4'(DEBOUNCE - 1)) begin
                        stable[i] <= ~stable[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic unused_cfg;

    assign stable     = raw;
    assign unused_cfg = ^{SAMPLE_DIV, DEBOUNCE};
`endif

    assign rise    = stable & ~stable_d;
    assign vs_rise = vs_s2 & ~vs_s3;

    // Delayed stable vector for edge detection; vsync synchronizer resets high
    // so a vsync already high at reset release is not seen as a frame edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stable_d <= '0;
            vs_s1    <= 1'b1;
            vs_s2    <= 1'b1;
            vs_s3    <= 1'b1;
        end else begin
            stable_d <= stable;
            vs_s1    <= vsync;
            vs_s2    <= vs_s1;
            vs_s3    <= vs_s2;
        end
    end

    // Frame latch; a press edge coinciding with the latch carries into next frame
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            act_held     <= '0;
            act_press    <= '0;
            pend         <= '0;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= vs_rise;
            if (vs_rise) begin
                act_held  <= stable[3:0];
                act_press <= pend;
                pend      <= rise[3:0];
            end else begin
                pend <= pend | rise[3:0];
            end
        end
    end

    // Menu events, priority Enter > Up > Down; lower simultaneous edges dropped
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            menu_valid <= 1'b0;
            menu_key   <= '0;
        end else begin
            menu_valid <= |rise[6:4];
            if (rise[4]) begin
                menu_key <= KEY_ENTER;
            end else if (rise[5]) begin
                menu_key <= KEY_UP;
            end else if (rise[6]) begin
                menu_key <= KEY_DOWN;
            end
        end
    end

endmodule

// File: tb/tb_keycode_frame_input.sv
// Directed bench for keycode_frame_input (SAMPLE_DIV=10, DEBOUNCE=4).
// Expectations that differ between the debounced and pass-through builds are
// selected with KEYIN_DEBOUNCE_EN.
module tb_keycode_frame_input;

    logic        Clk;
    logic        Reset_n;
    logic [31:0] keycode0;
    logic [31:0] keycode1;
    logic        vsync;
    logic [3:0]  act_held;
    logic [3:0]  act_press;
    logic        frame_strobe;
    logic [7:0]  menu_key;
    logic        menu_valid;

    int compared;
    int mismatched;
    int cyc;

    keycode_frame_input #(
        .SAMPLE_DIV (10),
        .DEBOUNCE   (4)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .keycode0     (keycode0),
        .keycode1     (keycode1),
        .vsync        (vsync),
        .act_held     (act_held),
        .act_press    (act_press),
        .frame_strobe (frame_strobe),
        .menu_key     (menu_key),
        .menu_valid   (menu_valid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Clock edges since reset release; tick edges are multiples of 10
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise vsync now (called at a negedge) and check the resulting snapshot
    task automatic frame(input string tag, input logic [3:0] exp_held, input logic [3:0] exp_press);
        int n;
        n = 0;
        vsync = 1'b1;
        do begin
            @(negedge Clk);
            n++;
        end while (!frame_strobe && n < 8);
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_held"}, {28'd0, act_held}, {28'd0, exp_held});
        chk({tag, "_press"}, {28'd0, act_press}, {28'd0, exp_press});
        @(negedge Clk);
        chk({tag, "_strobe_1cyc"}, {31'd0, frame_strobe}, 32'd0);
        vsync = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic watch_menu(input int cycles, output int pulses, output logic [7:0] key);
        pulses = 0;
        key    = '0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge Clk);
            if (menu_valid) begin
                pulses++;
                key = menu_key;
            end
        end
    endtask

    initial begin
        int         pulses;
        int         strobes;
        logic [7:0] key;

        compared   = 0;
        mismatched = 0;
        Reset_n    = 1'b0;
        keycode0   = '0;
        keycode1   = '0;
        vsync      = 1'b0;

        // Reset state
        repeat (3) @(negedge Clk);
        chk("rst_held", {28'd0, act_held}, 32'd0);
        chk("rst_press", {28'd0, act_press}, 32'd0);
        chk("rst_strobe", {31'd0, frame_strobe}, 32'd0);
        chk("rst_menu_key", {24'd0, menu_key}, 32'd0);
        chk("rst_menu_valid", {31'd0, menu_valid}, 32'd0);
        Reset_n = 1'b1;

        // Debounced left press, then the same key still held next frame
        keycode0 = 32'h0000_0004;
        repeat (400) @(negedge Clk);
        frame("deb1", 4'b0001, 4'b0001);
        frame("deb2", 4'b0001, 4'b0000);

        // ErrorRollOver report must not drop the held key
        keycode0 = 32'h0000_0101;
        repeat (1000) @(negedge Clk);
        frame("rollover", 4'b0001, 4'b0000);
        keycode0 = 32'h0000_0004;
        repeat (60) @(negedge Clk);

        // Menu: Enter+Up together, release, Down in byte 3, release, Up alone
        keycode1 = 32'h0000_2852;
        watch_menu(600, pulses, key);
        chk("menu_ent_up_pulses", pulses, 1);
        chk("menu_ent_up_key", {24'd0, key}, 32'h28);
        keycode1 = '0;
        watch_menu(600, pulses, key);
        chk("menu_release_pulses", pulses, 0);
        chk("menu_key_holds", {24'd0, menu_key}, 32'h28);
        keycode0 = 32'h5100_0004;
        watch_menu(600, pulses, key);
        chk("menu_down_pulses", pulses, 1);
        chk("menu_down_key", {24'd0, key}, 32'h51);
        keycode0 = 32'h0000_0004;
        watch_menu(600, pulses, key);
        chk("menu_down_rel_pulses", pulses, 0);
        keycode1 = 32'h0052_0000;
        watch_menu(600, pulses, key);
        chk("menu_up_pulses", pulses, 1);
        chk("menu_up_key", {24'd0, key}, 32'h52);
        keycode1 = '0;
        repeat (600) @(negedge Clk);

        // Asynchronous reset mid-debounce, released with vsync high
        keycode0 = '0;
        repeat (25) @(negedge Clk);
        vsync = 1'b1;
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_held", {28'd0, act_held}, 32'd0);
        chk("arst_press", {28'd0, act_press}, 32'd0);
        chk("arst_strobe", {31'd0, frame_strobe}, 32'd0);
        chk("arst_menu_key", {24'd0, menu_key}, 32'd0);
        chk("arst_menu_valid", {31'd0, menu_valid}, 32'd0);
        keycode0 = 32'h0000_0004;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (frame_strobe) strobes++;
        end
        chk("rel_vsync_high_strobes", strobes, 0);
        vsync = 1'b0;
        repeat (3) @(negedge Clk);
`ifdef KEYIN_DEBOUNCE_EN
        frame("post_rst1", 4'b0000, 4'b0000);
        repeat (400) @(negedge Clk);
        frame("post_rst2", 4'b0001, 4'b0001);
`else
        frame("post_rst1", 4'b0001, 4'b0001);
        repeat (400) @(negedge Clk);
        frame("post_rst2", 4'b0001, 4'b0000);
`endif

        // Bouncing jump key in word 1, byte 3
        for (int i = 0; i < 30; i++) begin
            keycode1 = (i % 2 == 0) ? 32'h1A00_0000 : 32'h0000_0000;
            repeat (15) @(negedge Clk);
        end
        repeat (60) @(negedge Clk);
`ifdef KEYIN_DEBOUNCE_EN
        frame("bounce", 4'b0001, 4'b0000);
`else
        frame("bounce", 4'b0001, 4'b0100);
`endif

        // Kick press edge lands exactly in the frame latch cycle
        while (cyc % 10 != 0) @(negedge Clk);
        keycode0 = 32'h0000_2C04;
`ifdef KEYIN_DEBOUNCE_EN
        repeat (38) @(negedge Clk);
`endif
        frame("kick_edge_frame", 4'b1001, 4'b0000);
        frame("kick_next_frame", 4'b1001, 4'b1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
